// File: rtl/accum_core_pkg.sv
// Shared opcode encoding and instruction field layout for the accumulator core.
package accum_core_pkg;

    // Instruction word: opcode occupies the OPC_W bits above the DATA_W-bit immediate.
    localparam int OPC_W   = 4;
    localparam int IMM_LSB = 0;

    localparam logic [OPC_W-1:0] OP_NOP  = 4'h0;
    localparam logic [OPC_W-1:0] OP_LDI  = 4'h1;
    localparam logic [OPC_W-1:0] OP_ADDI = 4'h2;
    localparam logic [OPC_W-1:0] OP_SUBI = 4'h3;
    localparam logic [OPC_W-1:0] OP_ANDI = 4'h4;
    localparam logic [OPC_W-1:0] OP_ORI  = 4'h5;
    localparam logic [OPC_W-1:0] OP_XORI = 4'h6;
    localparam logic [OPC_W-1:0] OP_NOT  = 4'h7;
    localparam logic [OPC_W-1:0] OP_JMP  = 4'h8;
    localparam logic [OPC_W-1:0] OP_JZ   = 4'h9;
    localparam logic [OPC_W-1:0] OP_CALL = 4'hA;
    localparam logic [OPC_W-1:0] OP_RET  = 4'hB;
    localparam logic [OPC_W-1:0] OP_HLT  = 4'hF;

endpackage

// File: rtl/accum_core_call_stack.sv
// Return-address LIFO; push when full and pop when empty are ignored here.
module call_stack #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] datain,
    output logic [WIDTH-1:0] dataout,
    output logic             full,
    output logic             empty
);

    localparam int SP_W = $clog2(DEPTH + 1);
    localparam logic [SP_W-1:0] SP_MAX = SP_W'(DEPTH);

    logic [WIDTH-1:0] entries [DEPTH];
    logic [SP_W-1:0]  sp;

    assign full  = (sp == SP_MAX);
    assign empty = (sp == '0);

    // Top of stack is entries[sp-1]; reads zero when empty.
    always_comb begin
        dataout = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (SP_W'(i + 1) == sp) dataout = entries[i];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sp <= '0;
        end else if (push && !full) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (SP_W'(i) == sp) entries[i] <= datain;
            end
            sp <= sp + SP_W'(1);
        end else if (pop && !empty) begin
            sp <= sp - SP_W'(1);
        end
    end

endmodule

// File: rtl/accum_core.sv
// Accumulator processor: loadable program memory, PC with jump/call/return,
// hardware return stack, one instruction retired per clock.
module accum_core
    import accum_core_pkg::*;
#(
    parameter int DATA_W      = 8,
    parameter int ADDR_W      = 4,
    parameter int STACK_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  prog_we,
    input  logic [ADDR_W-1:0]     prog_addr,
    input  logic [DATA_W+3:0]     prog_data,
    input  logic                  run,
    output logic [DATA_W-1:0]     acc_out,
    output logic [ADDR_W-1:0]     pc_out,
    output logic                  zero,
    output logic                  halted,
    output logic                  stack_err
);

    localparam int INSTR_W = DATA_W + OPC_W;

    logic [INSTR_W-1:0] prog_mem [2**ADDR_W];
    logic [INSTR_W-1:0] instr;
    logic [OPC_W-1:0]   opcode;
    logic [DATA_W-1:0]  imm;
    logic [ADDR_W-1:0]  tgt;
    logic [ADDR_W-1:0]  pc_seq;
    logic [ADDR_W-1:0]  ret_addr;
    logic [DATA_W-1:0]  acc;
    logic [ADDR_W-1:0]  pc;
    logic               halt_q;
    logic               err_q;
    logic               exec;
    logic               push;
    logic               pop;
    logic               full;
    logic               empty;

    // Memory is deliberately left out of reset so a program survives it.
    always_ff @(posedge clk) begin
        if (prog_we && !reset) prog_mem[prog_addr] <= prog_data;
    end

    assign instr  = prog_mem[pc];
    assign opcode = instr[DATA_W +: OPC_W];
    assign imm    = instr[IMM_LSB +: DATA_W];
    assign tgt    = imm[ADDR_W-1:0];
    assign pc_seq = pc + ADDR_W'(1);

    assign exec = run && !prog_we && !halt_q && !reset;
    assign push = exec && (opcode == OP_CALL) && !full;
    assign pop  = exec && (opcode == OP_RET) && !empty;

    call_stack #(
        .WIDTH (ADDR_W),
        .DEPTH (STACK_DEPTH)
    ) u_call_stack (
        .clk     (clk),
        .reset   (reset),
        .push    (push),
        .pop     (pop),
        .datain  (pc_seq),
        .dataout (ret_addr),
        .full    (full),
        .empty   (empty)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            acc    <= '0;
            pc     <= '0;
            halt_q <= 1'b0;
            err_q  <= 1'b0;
        end else if (exec) begin
            case (opcode)
                OP_LDI:  begin acc <= imm;        pc <= pc_seq; end
                OP_ADDI: begin acc <= acc + imm;  pc <= pc_seq; end
                OP_SUBI: begin acc <= acc - imm;  pc <= pc_seq; end
                OP_ANDI: begin acc <= acc & imm;  pc <= pc_seq; end
                OP_ORI:  begin acc <= acc | imm;  pc <= pc_seq; end
                OP_XORI: begin acc <= acc ^ imm;  pc <= pc_seq; end
                OP_NOT:  begin acc <= ~acc;       pc <= pc_seq; end
                OP_JMP:  pc <= tgt;
                OP_JZ:   pc <= (acc == '0) ? tgt : pc_seq;
                OP_CALL: begin
                    if (full) begin
                        err_q  <= 1'b1;
                        halt_q <= 1'b1;
                    end else begin
                        pc <= tgt;
                    end
                end
                OP_RET: begin
                    if (empty) begin
                        err_q  <= 1'b1;
                        halt_q <= 1'b1;
                    end else begin
                        pc <= ret_addr;
                    end
                end
                OP_HLT:  halt_q <= 1'b1;
                default: pc <= pc_seq;
            endcase
        end
    end

    assign acc_out   = acc;
    assign pc_out    = pc;
    assign zero      = (acc == '0);
    assign halted    = halt_q;
    assign stack_err = err_q;

endmodule

// File: doc/accum_core.md
Name: accum_core

Overview:
- Parametrised accumulator microprocessor. Successor to the 1-bit single-program core.
- Contains a loadable program memory, a program counter with jump/call/return, a hardware return stack, and a DATA_W-bit accumulator.
- Top-level compute block of the processor subsystem. Program is loaded by the testbench or host through a write port, then executed at one instruction per clock.

Parameters:
- DATA_W, 8: accumulator and immediate width. Must be >= ADDR_W.
- ADDR_W, 4: program address width. Depth is 2**ADDR_W words.
- STACK_DEPTH, 4: return-stack entries. Must be >= 1.

Ports:
- clk, input, 1: rising-edge clock.
- reset, input, 1: synchronous, active-high reset.
- prog_we, input, 1: program write strobe.
- prog_addr, input, ADDR_W: program write address.
- prog_data, input, 4+DATA_W: instruction word. Bits [DATA_W+3:DATA_W] are the opcode; bits [DATA_W-1:0] are the immediate.
- run, input, 1: execute enable.
- acc_out, output, DATA_W: accumulator value.
- pc_out, output, ADDR_W: current program counter.
- zero, output, 1: combinational flag, acc_out == 0.
- halted, output, 1: core stopped.
- stack_err, output, 1: sticky stack overflow or underflow.

Behaviour:
- Reset (synchronous, active-high; clock on clk):
  - On a clk edge with reset=1: acc=0, pc=0, sp=0, halted=0, stack_err=0.
  - Program memory is not cleared.
  - reset overrides every other input, including mid-program and while halted.
- Program write:
  - prog_we=1 writes prog_data to mem[prog_addr] at the clk edge.
  - Read is combinational at pc.
  - prog_we=1 stalls execution that cycle: pc, acc and stack are unchanged, even if run=1.
- Execute condition: run=1, prog_we=0, halted=0, reset=0. Exactly one instruction retires per clk edge.
- Latency: the result is visible on acc_out/pc_out the cycle after the edge. There is no pipeline and no hazards.
- Opcodes (imm = low DATA_W bits, tgt = imm[ADDR_W-1:0]):
  - 0 NOP: pc+1.
  - 1 LDI: acc=imm.
  - 2 ADDI: acc=acc+imm, modulo 2**DATA_W, carry discarded.
  - 3 SUBI: acc=acc-imm, modulo, borrow discarded.
  - 4 ANDI, 5 ORI, 6 XORI: bitwise with imm.
  - 7 NOT: acc=~acc.
  - 8 JMP: pc=tgt.
  - 9 JZ: pc=tgt if zero else pc+1. zero is evaluated on acc before the edge.
  - A CALL: push pc+1, pc=tgt.
  - B RET: pop into pc.
  - F HLT: halted=1, pc unchanged.
  - C,D,E: treated as NOP.
- All non-branch opcodes advance pc=pc+1. pc wraps from 2**ADDR_W-1 to 0 with no error.
- Stack:
  - Pushed return addresses wrap identically.
  - sp ranges 0..STACK_DEPTH.
  - CALL with sp==STACK_DEPTH: no push, stack_err=1, halted=1, pc unchanged.
  - RET with sp==0: stack_err=1, halted=1, pc unchanged.
  - acc is untouched on stack errors.
- Halt:
  - Only reset clears halted and stack_err.
  - While halted, prog_we still writes memory.
  - run=0 freezes the core; it resumes at the same pc when run=1.

Decomposition:
- Package accum_core_pkg:
  - 4-bit opcode localparams: OP_NOP..OP_HLT.
  - Opcode field position constants.
- Sub-module call_stack:
  - Parametrised LIFO (WIDTH=ADDR_W, DEPTH=STACK_DEPTH).
  - Ports: clk, reset, push, pop, datain, dataout, full, empty.
  - Ignores push when full and pop when empty; the core raises stack_err.
- Program memory and the decode/execute logic live inline in accum_core.

Test Plan:
- Reset then arithmetic, DATA_W=8:
  - Stimulus: load LDI 0x05, ADDI 0xFE, HLT. Pulse reset, run=1.
  - Required response: acc 0x05 then 0x03 (wrap). halted=1 with pc=2 after 3 edges.
- Loop with JZ, DATA_W=8:
  - Stimulus: LDI 3; SUBI 1; JZ 4; JMP 1; HLT.
  - Required response: acc 3,2,1,0. Final pc=4, halted=1, zero=1.
- Call/return nesting, STACK_DEPTH=4:
  - Stimulus: CALL to a subroutine that does ORI 0x80 then RET.
  - Required response: pc returns to call+1, acc=0x80, stack_err=0.
- Overflow, STACK_DEPTH=2:
  - Stimulus: three nested CALLs.
  - Required response: third CALL sets stack_err=1 and halted=1, pc stays at the third CALL address.
  - Stimulus: RET at pc 0 after reset.
  - Required response: stack_err=1.
- Stall and freeze:
  - Stimulus: prog_we=1 for 2 cycles mid-run, then run=0 for 3 cycles.
  - Required response: pc and acc unchanged during both. Execution resumes at the same pc.
- Reset mid-program:
  - Stimulus: assert reset at cycle 5 of the loop test.
  - Required response: next edge gives acc=0, pc=0, halted=0, stack_err=0. Program memory is intact and reruns identically.
